pll_lock_manager: RTL and testbench



---
 rtl/pll_lock_manager_pkg.sv | 17 +
 rtl/pll_lock_manager_sync_bit.sv | 27 ++
 rtl/pll_lock_manager.sv | 177 +++++++++++++++++
 tb/tb_pll_lock_manager.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_manager_pkg.sv
// Types and helpers shared by the PLL lock supervisor and the status display logic.
package pll_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/pll_lock_manager_sync_bit.sv
// Generic multi-flop synchroniser for a single asynchronous bit, cleared by reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  if (STAGES < 2) begin : g_chk_stages
    $error("sync_bit: STAGES must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_manager.sv
// PLL supervisor: sequences the PLL reset, qualifies lock over a stable window,
// filters lock loss, retries automatically and latches a fault after too many failures.
module pll_lock_manager
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 3,
  localparam int CORDW        = $clog2(MAX_RETRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked_raw,
  output logic             pll_rst,
  output logic             clk_locked,
  output logic             lock_lost,
  output logic             fault,
  output logic [CORDW-1:0] retry_count,
  output logic [2:0]       state
);

  localparam int RST_W  = cnt_width(RST_CYCLES);
  localparam int TO_W   = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W  = cnt_width(STABLE_CYCLES);
  localparam int LOSS_W = cnt_width(LOSS_FILTER);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [CORDW-1:0]  RETRY_MAX = CORDW'(MAX_RETRIES);
  // The WAIT_LOCK cycle that first sees lock already counts towards the window,
  // so STABLE itself needs one cycle fewer than STABLE_CYCLES.
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(STABLE_CYCLES - 2);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("pll_lock_manager: SYNC_STAGES must be at least 2");
  end
  if (RST_CYCLES < 1) begin : g_chk_rst
    $error("pll_lock_manager: RST_CYCLES must be at least 1");
  end
  if (STABLE_CYCLES < 1) begin : g_chk_stable
    $error("pll_lock_manager: STABLE_CYCLES must be at least 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_chk_timeout
    $error("pll_lock_manager: LOCK_TIMEOUT must be at least 1");
  end
  if (LOSS_FILTER < 1) begin : g_chk_loss
    $error("pll_lock_manager: LOSS_FILTER must be at least 1");
  end
  if (MAX_RETRIES < 1) begin : g_chk_retries
    $error("pll_lock_manager: MAX_RETRIES must be at least 1");
  end

  pll_state_t        r_state;
  logic              r_pll_rst;
  logic              r_clk_locked;
  logic              r_lock_lost;
  logic              r_fault;
  logic [CORDW-1:0]  r_retry;
  logic [RST_W-1:0]  r_rst_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [STB_W-1:0]  r_stb_cnt;
  logic [LOSS_W-1:0] r_loss_cnt;

  logic              w_lock_s;
  logic              w_timeout;
  logic              w_fail;
  logic [CORDW-1:0]  w_retry_inc;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked_raw),
    .q   (w_lock_s)
  );

  assign w_timeout   = (r_to_cnt == TO_LAST);
  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + CORDW'(1);

  // Timeout has priority over every lock_s decision in WAIT_LOCK and STABLE.
  assign w_fail = (((r_state == WAIT_LOCK) || (r_state == STABLE)) && w_timeout) ||
                  ((r_state == LOCKED) && !w_lock_s && (r_loss_cnt == LOSS_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET;
      r_pll_rst    <= 1'b1;
      r_clk_locked <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_fault      <= 1'b0;
      r_retry      <= '0;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_stb_cnt    <= '0;
      r_loss_cnt   <= '0;
    end else begin
      r_lock_lost <= 1'b0;
      if (w_fail) begin
        r_retry      <= w_retry_inc;
        r_pll_rst    <= 1'b1;
        r_clk_locked <= 1'b0;
        r_lock_lost  <= (r_state == LOCKED);
        r_rst_cnt    <= '0;
        if (w_retry_inc == RETRY_MAX) begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end else begin
          r_state <= RESET;
        end
      end else begin
        case (r_state)
          RESET: begin
            if (r_rst_cnt == RST_LAST) begin
              r_state   <= WAIT_LOCK;
              r_pll_rst <= 1'b0;
              r_to_cnt  <= '0;
            end else begin
              r_rst_cnt <= r_rst_cnt + RST_W'(1);
            end
          end
          WAIT_LOCK: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_lock_s) begin
              r_stb_cnt  <= '0;
              r_loss_cnt <= '0;
              if (STABLE_CYCLES == 1) begin
                r_state      <= LOCKED;
                r_clk_locked <= 1'b1;
              end else begin
                r_state <= STABLE;
              end
            end
          end
          STABLE: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            if (!w_lock_s) begin
              r_state <= WAIT_LOCK;
            end else if (r_stb_cnt == STB_LAST) begin
              r_state      <= LOCKED;
              r_clk_locked <= 1'b1;
              r_loss_cnt   <= '0;
            end else begin
              r_stb_cnt <= r_stb_cnt + STB_W'(1);
            end
          end
          LOCKED: begin
            r_loss_cnt <= w_lock_s ? '0 : r_loss_cnt + LOSS_W'(1);
          end
          FAULT: begin
            r_pll_rst    <= 1'b1;
            r_clk_locked <= 1'b0;
            r_fault      <= 1'b1;
          end
          default: begin
            r_state      <= RESET;
            r_pll_rst    <= 1'b1;
            r_clk_locked <= 1'b0;
            r_rst_cnt    <= '0;
          end
        endcase
      end
    end
  end

  assign pll_rst     = r_pll_rst;
  assign clk_locked  = r_clk_locked;
  assign lock_lost   = r_lock_lost;
  assign fault       = r_fault;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_lock_manager.sv
// Bench for pll_lock_manager: directed scenarios with literal expectations plus random
// lock waveforms, all checked every cycle against an attempt-level behavioural model.
module tb_pll_lock_manager;

  localparam int SYNC = 2;
  localparam int RSTC = 4;
  localparam int STB  = 8;
  localparam int LT   = 32;
  localparam int LF   = 3;
  localparam int MAXR = 2;
  localparam int CW   = $clog2(MAXR + 1);
  localparam int NREC = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          raw = 1'b0;
  logic          pll_rst;
  logic          clk_locked;
  logic          lock_lost;
  logic          fault;
  logic [CW-1:0] retry_count;
  logic [2:0]    state;

  int n_vec = 0;
  int n_err = 0;

  pll_lock_manager #(
    .SYNC_STAGES   (SYNC),
    .RST_CYCLES    (RSTC),
    .STABLE_CYCLES (STB),
    .LOCK_TIMEOUT  (LT),
    .LOSS_FILTER   (LF),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked_raw (raw),
    .pll_rst        (pll_rst),
    .clk_locked     (clk_locked),
    .lock_lost      (lock_lost),
    .fault          (fault),
    .retry_count    (retry_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 PLL held in reset, 1 acquiring lock, 2 locked, 3 fault.
  int              m_phase, m_rcnt, m_t, m_hi, m_lo, m_retries;
  bit              m_lost, m_valid;
  logic [SYNC-1:0] m_sync;

  task automatic model_fail();
    if (m_retries < MAXR) m_retries++;
    if (m_retries == MAXR) m_phase = 3;
    else begin
      m_phase = 0;
      m_rcnt  = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic d);
    logic ls;
    if (r) begin
      m_phase = 0; m_rcnt = 0; m_retries = 0; m_lost = 0;
      m_sync = '0; m_valid = 1;
      return;
    end
    ls     = m_sync[SYNC-1];
    m_sync = {m_sync[SYNC-2:0], d};
    m_lost = 0;
    case (m_phase)
      0: begin
        m_rcnt++;
        if (m_rcnt == RSTC) begin m_phase = 1; m_t = 0; m_hi = 0; end
      end
      1: begin
        m_t++;
        if (m_t == LT) model_fail();
        else if (ls) begin
          m_hi++;
          if (m_hi >= STB) begin m_phase = 2; m_lo = 0; end
        end else m_hi = 0;
      end
      2: begin
        if (!ls) begin
          m_lo++;
          if (m_lo == LF) begin m_lost = 1; model_fail(); end
        end else m_lo = 0;
      end
      default: ;
    endcase
  endtask

  function automatic int m_exp_state();
    case (m_phase)
      0:       return 0;
      1:       return (m_hi == 0) ? 1 : 2;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  initial begin
    int exp_v, act_v;
    m_valid = 0;
    forever begin
      @(posedge clk);
      model_step(rst, raw);
      @(negedge clk);
      if (m_valid) begin
        exp_v = ((m_phase == 0 || m_phase == 3) ? 256 : 0) | ((m_phase == 2) ? 128 : 0) |
                (m_lost ? 64 : 0) | ((m_phase == 3) ? 32 : 0) | (m_retries << 3) | m_exp_state();
        act_v = (int'(pll_rst) << 8) | (int'(clk_locked) << 7) | (int'(lock_lost) << 6) |
                (int'(fault) << 5) | (int'(retry_count) << 3) | int'(state);
        n_vec++;
        if (act_v != exp_v) begin
          n_err++;
          $display("FAIL cycle_cmp t=%0t: got pll_rst=%0d locked=%0d lost=%0d fault=%0d retry=%0d state=%0d, expected %0d %0d %0d %0d %0d %0d",
                   $time, pll_rst, clk_locked, lock_lost, fault, retry_count, state,
                   (exp_v >> 8) & 1, (exp_v >> 7) & 1, (exp_v >> 6) & 1, (exp_v >> 5) & 1,
                   (exp_v >> 3) & 3, exp_v & 7);
        end
      end
    end
  end

  // ---------------- directed recording ----------------
  int r_pll [NREC];
  int r_lk  [NREC];
  int r_ll  [NREC];
  int r_ft  [NREC];
  int r_rc  [NREC];
  int r_st  [NREC];
  int r_mlk [NREC];

  function automatic logic [NREC-1:0] span(input int lo, input int hi);
    logic [NREC-1:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Cycle 0 is the cycle right after the last edge that samples rst high.
  task automatic run_dir(input logic [NREC-1:0] raw_pat, input logic [NREC-1:0] rst_pat, input int n);
    @(posedge clk); #1; rst = 1'b1; raw = 1'b0;
    @(posedge clk); #1; rst = rst_pat[0]; raw = raw_pat[0];
    for (int idx = 0; idx < n; idx++) begin
      @(negedge clk);
      r_pll[idx] = int'(pll_rst);
      r_lk[idx]  = int'(clk_locked);
      r_ll[idx]  = int'(lock_lost);
      r_ft[idx]  = int'(fault);
      r_rc[idx]  = int'(retry_count);
      r_st[idx]  = int'(state);
      r_mlk[idx] = (m_phase == 2) ? 1 : 0;
      @(posedge clk); #1;
      if (idx + 1 < NREC) begin
        rst = rst_pat[idx + 1];
        raw = raw_pat[idx + 1];
      end
    end
  endtask

  function automatic int first_lock(input int from, input int n);
    for (int i = from; i < n; i++) if (r_lk[i] == 1) return i;
    return -1;
  endfunction

  function automatic int pll_rst_len(input int from, input int n);
    int c;
    c = 0;
    for (int i = from; i < n && r_pll[i] == 1; i++) c++;
    return c;
  endfunction

  task automatic check_nominal(input string tag);
    int mrise;
    run_dir(span(6, NREC - 1), '0, 30);
    mrise = -1;
    for (int i = 29; i >= 0; i--) if (r_mlk[i] == 1) mrise = i;
    chk({tag, "_reset_state"}, r_st[0], 0);
    chk({tag, "_reset_fault"}, r_ft[0], 0);
    chk({tag, "_reset_retry"}, r_rc[0], 0);
    chk({tag, "_pll_rst_len"}, pll_rst_len(0, 30), 4);
    chk({tag, "_lock_rise"}, first_lock(0, 30), 16);
    chk({tag, "_model_rise"}, mrise, 16);
    chk({tag, "_state_locked"}, r_st[16], 3);
    chk({tag, "_retry"}, r_rc[29], 0);
    $display("scenario %s: lock rise at cycle %0d", tag, first_lock(0, 30));
  endtask

  initial begin
    int lost_cnt, lost_at, hold_cnt, run_left;

    rst = 1'b1; raw = 1'b0;
    repeat (3) @(posedge clk);

    check_nominal("nominal");

    // Stability restart: high 6-10, low 11, high from 12.
    run_dir(span(6, 10) | span(12, NREC - 1), '0, 30);
    chk("restart_lock_rise", first_lock(0, 30), 22);
    chk("restart_retry", r_rc[29], 0);
    $display("scenario restart: lock rise at cycle %0d", first_lock(0, 30));

    // Glitch filter: 2-cycle drop at 20-21 is ignored, 3-cycle drop at 30-32 is a loss.
    run_dir(span(6, 19) | span(22, 29) | span(33, NREC - 1), '0, 60);
    hold_cnt = 0;
    for (int i = 16; i <= 34; i++) hold_cnt += r_lk[i];
    lost_cnt = 0; lost_at = -1;
    for (int i = 0; i < 60; i++) if (r_ll[i] == 1) begin lost_cnt++; lost_at = i; end
    chk("glitch_hold_cycles", hold_cnt, 19);
    chk("glitch_lost_pulses", lost_cnt, 1);
    chk("glitch_lost_cycle", lost_at, 35);
    chk("glitch_locked_drop", r_lk[35], 0);
    chk("glitch_retry", r_rc[35], 1);
    chk("glitch_pll_rst_len", pll_rst_len(35, 60), 4);
    chk("glitch_relock", first_lock(36, 60), 47);
    chk("glitch_retry_kept", r_rc[59], 1);
    $display("scenario glitch: lock_lost at cycle %0d, relock at %0d", lost_at, first_lock(36, 60));

    // Timeouts into FAULT, then raw lock rises while faulted.
    run_dir(span(75, NREC - 1), '0, 110);
    chk("timeout_wait_state", r_st[35], 1);
    chk("timeout_retry_before", r_rc[35], 0);
    chk("timeout_reset_state", r_st[36], 0);
    chk("timeout_retry_after", r_rc[36], 1);
    chk("timeout_fault_before", r_ft[71], 0);
    chk("timeout_fault", r_ft[72], 1);
    chk("timeout_fault_state", r_st[72], 4);
    chk("timeout_fault_pll_rst", r_pll[72], 1);
    chk("fault_sticky_fault", r_ft[109], 1);
    chk("fault_sticky_state", r_st[109], 4);
    chk("fault_sticky_pll_rst", r_pll[109], 1);
    chk("fault_sticky_locked", r_lk[109], 0);
    chk("fault_sticky_retry", r_rc[109], 2);
    $display("scenario timeout/fault: fault at cycle 72 observed=%0d", r_ft[72]);

    check_nominal("recover");

    // One-cycle rst while in STABLE.
    run_dir(span(6, NREC - 1), span(12, 12), 30);
    chk("midrst_stable_state", r_st[12], 2);
    chk("midrst_state", r_st[13], 0);
    chk("midrst_retry", r_rc[13], 0);
    chk("midrst_pll_rst", r_pll[13], 1);
    chk("midrst_locked_before", r_lk[24], 0);
    chk("midrst_relock", r_lk[25], 1);
    $display("scenario mid-stable reset: relock at cycle %0d", first_lock(13, 30));

    // Random lock waveforms with occasional resets.
    run_left = 0;
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      if (run_left == 0) begin
        raw = 1'($urandom_range(0, 1));
        run_left = raw ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 6));
        if ($urandom_range(0, 9) == 0) run_left = int'($urandom_range(20, 60));
      end else begin
        run_left--;
      end
    end
    $display("random phase: 6000 cycles applied");

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
